// File: rtl/crc_stream_if.sv
// Beat stream in, CRC result out: the handshake bundle around crc_stream.
// The master drives beats and result-ready; the slave is the CRC engine.
interface crc_stream_if #(
   parameter int DATA_W = 8,
   parameter int CRC_W  = 16,
   parameter int LEN_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_first;
   logic              in_last;
   logic              crc_valid;
   logic              crc_ready;
   logic [CRC_W-1:0]  crc_out;
   logic [LEN_W-1:0]  crc_len;
   logic              proto_err;

   modport master (
      output in_valid, in_data, in_first, in_last, crc_ready,
      input  in_ready, crc_valid, crc_out, crc_len, proto_err
   );

   modport slave (
      input  in_valid, in_data, in_first, in_last, crc_ready,
      output in_ready, crc_valid, crc_out, crc_len, proto_err
   );
endinterface

// File: rtl/crc_stream.sv
// Streaming CRC engine: folds DATA_W bits per accepted beat into the running
// remainder and posts the final CRC plus beat count on a held result port.
module crc_stream #(
   parameter int               DATA_W      = 8,
   parameter int               CRC_W       = 16,
   parameter logic [CRC_W-1:0] POLY        = 16'h1021,
   parameter logic [CRC_W-1:0] INIT        = 16'hFFFF,
   parameter logic [CRC_W-1:0] XOR_OUT     = 16'h0000,
   parameter bit               REFLECT_IN  = 1'b0,
   parameter bit               REFLECT_OUT = 1'b0,
   parameter int               LEN_W       = 16
) (
   input logic         clk,
   input logic         rst,
   crc_stream_if.slave bus
);

   typedef enum logic {S_IDLE, S_OPEN} state_t;

   state_t            state_q, state_d;
   logic [CRC_W-1:0]  rem_q, rem_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [CRC_W-1:0]  crc_q, crc_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              err_q, err_d;

   logic              accept, start;
   logic [DATA_W-1:0] beat;
   logic [CRC_W-1:0]  folded;
   logic [LEN_W-1:0]  cnt_n;

   function automatic logic [DATA_W-1:0] rev_data(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
      return r;
   endfunction

   function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] x);
      logic [CRC_W-1:0] r;
      for (int i = 0; i < CRC_W; i++) r[i] = x[CRC_W-1-i];
      return r;
   endfunction

   // MSB-first bit-serial division, unrolled across the whole beat.
   function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] seed,
                                             input logic [DATA_W-1:0] d);
      logic [CRC_W-1:0] r;
      logic             fb;
      r = seed;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb = r[CRC_W-1] ^ d[i];
         r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return r;
   endfunction

   assign bus.in_ready  = !valid_q | bus.crc_ready;
   assign bus.crc_valid = valid_q;
   assign bus.crc_out   = crc_q;
   assign bus.crc_len   = len_q;
   assign bus.proto_err = err_q;

   // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      crc_d   = crc_q;
      len_d   = len_q;
      err_d   = 1'b0;

      accept = bus.in_valid & bus.in_ready;
      start  = bus.in_first | (state_q == S_IDLE);
      beat   = REFLECT_IN ? rev_data(bus.in_data) : bus.in_data;
      folded = fold(start ? INIT : rem_q, beat);
      cnt_n  = start ? LEN_W'(1)
                     : ((&cnt_q) ? cnt_q : cnt_q + LEN_W'(1));

      if (valid_q && bus.crc_ready) valid_d = 1'b0;

      if (accept) begin
         // A first beat inside an open frame, or a non-first beat with no frame open.
         err_d = (bus.in_first == (state_q == S_OPEN));
         if (bus.in_last) begin
            crc_d   = (REFLECT_OUT ? rev_crc(folded) : folded) ^ XOR_OUT;
            len_d   = cnt_n;
            valid_d = 1'b1;
            rem_d   = INIT;
            cnt_d   = '0;
            state_d = S_IDLE;
         end else begin
            rem_d   = folded;
            cnt_d   = cnt_n;
            state_d = S_OPEN;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= INIT;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         crc_q   <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         crc_q   <= crc_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench for crc_stream: CRC-16/CCITT-FALSE, CRC-32 and a 7-in/3-bit
// configuration driven with directed vectors whose results are known by hand.
module tb_crc_stream;

   typedef struct packed {
      logic [63:0] crc;
      logic [15:0] len;
   } exp_t;

   logic clk;
   logic rst;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   err16 = 0, err32 = 0, err7 = 0;
   exp_t q16[$];
   exp_t q32[$];
   exp_t q7[$];

   logic [7:0] msg [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
   logic [6:0] v7  [0:5] = '{7'b1001001, 7'b0000000, 7'b1111111, 7'b0101010, 7'b1010101, 7'b0011100};

   crc_stream_if #(.DATA_W(8), .CRC_W(16), .LEN_W(16)) if16 ();
   crc_stream_if #(.DATA_W(8), .CRC_W(32), .LEN_W(16)) if32 ();
   crc_stream_if #(.DATA_W(7), .CRC_W(3),  .LEN_W(16)) if7 ();

   crc_stream #(.DATA_W(8), .CRC_W(16)) dut16 (
      .clk(clk), .rst(rst), .bus(if16.slave)
   );

   crc_stream #(
      .DATA_W(8), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
      .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .LEN_W(16)
   ) dut32 (
      .clk(clk), .rst(rst), .bus(if32.slave)
   );

   crc_stream #(
      .DATA_W(7), .CRC_W(3), .POLY(3'b001), .INIT(3'b000), .XOR_OUT(3'b000),
      .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .LEN_W(16)
   ) dut7 (
      .clk(clk), .rst(rst), .bus(if7.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] crc, input logic [15:0] len);
      exp_t e;
      e.crc = crc;
      e.len = len;
      return e;
   endfunction

   // Remainder of x^3*d(x) mod x^3+1: bit k collects the data bits with index = k mod 3.
   function automatic logic [2:0] exp3(input logic [6:0] d);
      return {d[2] ^ d[5], d[1] ^ d[4], d[0] ^ d[3] ^ d[6]};
   endfunction

   // Scoreboard monitors: pop one expectation per result handshake.
   always @(negedge clk) begin
      if (!rst && if16.crc_valid && if16.crc_ready) begin
         if (q16.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected16: got result %0h, expected none", if16.crc_out);
         end else begin
            exp_t e;
            e = q16.pop_front();
            check("crc16", 64'(if16.crc_out), e.crc);
            check("len16", 64'(if16.crc_len), 64'(e.len));
         end
      end
      if (!rst && if16.proto_err) err16++;
   end

   always @(negedge clk) begin
      if (!rst && if32.crc_valid && if32.crc_ready) begin
         if (q32.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected32: got result %0h, expected none", if32.crc_out);
         end else begin
            exp_t e;
            e = q32.pop_front();
            check("crc32", 64'(if32.crc_out), e.crc);
            check("len32", 64'(if32.crc_len), 64'(e.len));
         end
      end
      if (!rst && if32.proto_err) err32++;
   end

   always @(negedge clk) begin
      if (!rst && if7.crc_valid && if7.crc_ready) begin
         if (q7.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected7: got result %0h, expected none", if7.crc_out);
         end else begin
            exp_t e;
            e = q7.pop_front();
            check("crc3", 64'(if7.crc_out), e.crc);
            check("len3", 64'(if7.crc_len), 64'(e.len));
         end
      end
      if (!rst && if7.proto_err) err7++;
   end

   task automatic send16(input logic [7:0] d, input logic f, input logic l);
      int t;
      t = 0;
      if16.in_valid = 1'b1; if16.in_data = d; if16.in_first = f; if16.in_last = l;
      @(negedge clk);
      while (!if16.in_ready && t < 200) begin
         t++;
         @(negedge clk);
      end
      if (t >= 200) begin
         n_checks++; n_fail++;
         $display("FAIL timeout16: in_ready stayed %0b, expected 1", if16.in_ready);
      end
      @(posedge clk); #1;
      if16.in_valid = 1'b0; if16.in_data = 8'hA5; if16.in_first = 1'b1; if16.in_last = 1'b1;
   endtask

   task automatic send32(input logic [7:0] d, input logic f, input logic l);
      if32.in_valid = 1'b1; if32.in_data = d; if32.in_first = f; if32.in_last = l;
      @(negedge clk);
      check("rdy32", 64'(if32.in_ready), 64'd1);
      @(posedge clk); #1;
      if32.in_valid = 1'b0; if32.in_first = 1'b0; if32.in_last = 1'b0;
   endtask

   task automatic send7(input logic [6:0] d, input logic f, input logic l);
      if7.in_valid = 1'b1; if7.in_data = d; if7.in_first = f; if7.in_last = l;
      @(negedge clk);
      check("rdy7", 64'(if7.in_ready), 64'd1);
      @(posedge clk); #1;
      if7.in_valid = 1'b0; if7.in_first = 1'b0; if7.in_last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      rst = 1'b1;
      if16.in_valid = 1'b0; if16.in_data = '0; if16.in_first = 1'b0; if16.in_last = 1'b0;
      if32.in_valid = 1'b0; if32.in_data = '0; if32.in_first = 1'b0; if32.in_last = 1'b0;
      if7.in_valid  = 1'b0; if7.in_data  = '0; if7.in_first  = 1'b0; if7.in_last  = 1'b0;
      if16.crc_ready = 1'b1; if32.crc_ready = 1'b1; if7.crc_ready = 1'b1;

      #12;
      check("rst_valid", 64'(if16.crc_valid), 64'd0);
      check("rst_crc",   64'(if16.crc_out),   64'd0);
      check("rst_len",   64'(if16.crc_len),   64'd0);
      check("rst_err",   64'(if16.proto_err), 64'd0);
      check("rst_ready", 64'(if16.in_ready),  64'd1);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // "123456789", first on beat 0, last on beat 8
      q16.push_back(mk(64'h29B1, 16'd9));
      for (int i = 0; i < 9; i++) send16(msg[i], i == 0, i == 8);
      check("lat16", 64'(if16.crc_valid), 64'd1);
      idle(3);
      check("noerr16", 64'(err16), 64'd0);

      // Short frames with hand-derived CCITT-FALSE results
      q16.push_back(mk(64'hE1F0, 16'd1));
      send16(8'h00, 1'b1, 1'b1);
      q16.push_back(mk(64'hFF00, 16'd1));
      send16(8'hFF, 1'b1, 1'b1);
      q16.push_back(mk(64'h0000, 16'd2));
      send16(8'hFF, 1'b1, 1'b0);
      send16(8'hFF, 1'b0, 1'b1);
      idle(3);

      // Backpressure: frame 1 result held while frame 2 waits, then both handshakes in one cycle
      if16.crc_ready = 1'b0;
      q16.push_back(mk(64'h29B1, 16'd9));
      for (int i = 0; i < 9; i++) send16(msg[i], i == 0, i == 8);
      q16.push_back(mk(64'hE1F0, 16'd1));
      if16.in_valid = 1'b1; if16.in_data = 8'h00; if16.in_first = 1'b1; if16.in_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_ready", 64'(if16.in_ready),  64'd0);
         check("hold_valid", 64'(if16.crc_valid), 64'd1);
         check("hold_crc",   64'(if16.crc_out),   64'h29B1);
      end
      @(posedge clk); #1;
      if16.crc_ready = 1'b1;
      @(negedge clk);
      check("b2b_ready", 64'(if16.in_ready), 64'd1);
      @(posedge clk); #1;
      if16.in_valid = 1'b0; if16.in_first = 1'b0; if16.in_last = 1'b0;
      check("b2b_valid", 64'(if16.crc_valid), 64'd1);
      check("b2b_crc",   64'(if16.crc_out),   64'hE1F0);
      idle(3);

      // Aborted frame: three beats, then a new first beat restarts from INIT
      base = err16;
      q16.push_back(mk(64'h29B1, 16'd9));
      for (int i = 0; i < 3; i++) send16(msg[i], i == 0, 1'b0);
      for (int i = 0; i < 9; i++) send16(msg[i], i == 0, i == 8);
      idle(3);
      check("abort_err", 64'(err16 - base), 64'd1);

      // Frame without a first beat after idle: implicit start, still processed
      base = err16;
      q16.push_back(mk(64'h29B1, 16'd9));
      for (int i = 0; i < 9; i++) send16(msg[i], 1'b0, i == 8);
      idle(3);
      check("nofirst_err", 64'(err16 - base), 64'd1);

      // Asynchronous reset mid-frame
      send16(msg[0], 1'b1, 1'b0);
      send16(msg[1], 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("rstmid_valid", 64'(if16.crc_valid), 64'd0);
      check("rstmid_ready", 64'(if16.in_ready),  64'd1);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Asynchronous reset with a result pending
      if16.crc_ready = 1'b0;
      send16(8'hFF, 1'b1, 1'b1);
      check("pend_valid", 64'(if16.crc_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("rstpend_valid", 64'(if16.crc_valid), 64'd0);
      check("rstpend_crc",   64'(if16.crc_out),   64'd0);
      check("rstpend_len",   64'(if16.crc_len),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      if16.crc_ready = 1'b1;
      idle(2);

      base = err16;
      q16.push_back(mk(64'h29B1, 16'd9));
      for (int i = 0; i < 9; i++) send16(msg[i], i == 0, i == 8);
      idle(3);
      check("post_rst_err", 64'(err16 - base), 64'd0);

      // CRC-32 (reflected) check value
      q32.push_back(mk(64'hCBF43926, 16'd9));
      for (int i = 0; i < 9; i++) send32(msg[i], i == 0, i == 8);
      idle(3);

      // 7-bit beats into a 3-bit CRC, single-beat frames
      q7.push_back(mk(64'h1, 16'd1));
      send7(v7[0], 1'b1, 1'b1);
      for (int i = 1; i < 6; i++) begin
         q7.push_back(mk(64'(exp3(v7[i])), 16'd1));
         send7(v7[i], 1'b1, 1'b1);
      end
      idle(4);

      check("drain16", 64'(q16.size()), 64'd0);
      check("drain32", 64'(q32.size()), 64'd0);
      check("drain7",  64'(q7.size()),  64'd0);
      check("noerr32", 64'(err32), 64'd0);
      check("noerr7",  64'(err7),  64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
- Parametrised, pipelined streaming CRC engine and the successor to the fixed 7-bit/3-bit combinational CRC generator.
- Accepts a frame of DATA_W-bit beats over a valid/ready handshake and folds DATA_W bits into the running remainder each cycle.
- Presents the finished CRC and the frame beat count on a registered valid/ready result port.
- Sits between a packet source and a framer/checker; polynomial, init, reflection and final XOR are compile-time.

Parameters:
- DATA_W, 8, bits consumed per accepted beat (>=1).
- CRC_W, 16, CRC width (>=2, <=64).
- POLY, 16'h1021, generator polynomial, implicit x^CRC_W term omitted, normal (non-reflected) form.
- INIT, 16'hFFFF, remainder loaded at frame start.
- XOR_OUT, 16'h0000, XORed into final CRC.
- REFLECT_IN, 0, 1 = bit-reverse each in_data beat before folding.
- REFLECT_OUT, 0, 1 = bit-reverse final remainder before XOR_OUT.
- LEN_W, 16, width of beat counter / crc_len.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat present.
- in_ready  out  1  engine can accept a beat.
- in_data  in  DATA_W  beat data, bit DATA_W-1 folded first (before REFLECT_IN).
- in_first  in  1  beat is first of frame.
- in_last  in  1  beat is last of frame.
- crc_valid  out  1  result available.
- crc_ready  in  1  result consumer ready.
- crc_out  out  CRC_W  final CRC of completed frame.
- crc_len  out  LEN_W  beats in completed frame.
- proto_err  out  1  one-cycle pulse on framing violation.

Behaviour:
- Reset (async assert, sync release): rem=INIT, cnt=0, open=0, crc_valid=0, crc_out=0, crc_len=0, proto_err=0. in_ready=1 after reset.
- Accept: a beat transfers when in_valid & in_ready. in_ready = !crc_valid | crc_ready (combinational). A new beat may be accepted in the same cycle the result handshakes.
- Fold (per accepted beat): d = REFLECT_IN ? bitrev(in_data) : in_data; base = (in_first | !open) ? INIT : rem.
- Fold loop: for i = DATA_W-1 down to 0: fb = base[CRC_W-1]^d[i]; base = (base<<1) ^ (fb ? POLY : 0), truncated to CRC_W. The loop is fully unrolled combinationally in one cycle.
- Counting: beat count cnt_n = (in_first | !open) ? 1 : cnt+1, saturating at all-ones.
- Not last: rem<=base, cnt<=cnt_n, open<=1.
- Last: crc_out <= (REFLECT_OUT ? bitrev(base) : base) ^ XOR_OUT; crc_len<=cnt_n; crc_valid<=1 next cycle (latency 1 from last beat); rem<=INIT, cnt<=0, open<=0.
- Result hold: crc_valid stays high, crc_out/crc_len stable until crc_valid & crc_ready. Then crc_valid clears, unless a new last beat is accepted in that same cycle, which loads the new result and keeps crc_valid=1.
- Framing errors: proto_err pulses 1 cycle after an accepted beat with in_first=1 while open=1 (open frame aborted, restart from INIT, no result for aborted frame). Also pulses after an accepted beat with in_first=0 while open=0 (implicit start from INIT, frame still processed).
- Single-beat frame: first=last=1, result from INIT.
- in_valid low: no state change. in_data, in_first and in_last are ignored when not accepted.
- Reset mid-frame or with result pending: all state dropped, crc_valid=0 immediately.

Test Plan:
- Default params, frame bytes 0x31..0x39 ("123456789"), first on beat 0, last on beat 8, crc_ready=1 -> crc_valid one cycle after last, crc_out=16'h29B1, crc_len=9, proto_err never.
- CRC_W=32, POLY=32'h04C11DB7, INIT=XOR_OUT=32'hFFFFFFFF, REFLECT_IN=REFLECT_OUT=1, same 9 bytes -> crc_out=32'hCBF43926.
- DATA_W=7, CRC_W=3, POLY=3'b001, INIT=0, single beat 7'b1001001 first=last=1 -> crc_out=3'b001, crc_len=1. Random 7-bit beats match d0^d3^d6, d1^d4, d2^d5.
- Hold crc_ready=0 after frame 1 completes, present frame 2 -> in_ready=0, crc_out holds 16'h29B1. Raise crc_ready with frame 2's last beat valid -> both handshakes in one cycle, crc_valid stays 1 with frame 2 result.
- Send 3 bytes of a frame, then a beat with in_first=1, then "123456789" -> proto_err pulse once, only result 16'h29B1, crc_len=9. Separately, a beat with first=0 after idle -> proto_err pulse, result computed from INIT.
- Assert rst asynchronously mid-frame and again with crc_valid=1 -> crc_valid, crc_out and crc_len drop to 0 without a clock edge. A following clean frame gives the correct CRC.
